// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the per-core arbitration submodules and the round-robin bus arbiter.
// The master modport is the arbiter side; the slave modport is the requester/memory side.
interface bus_arbiter_rr_if #(
    parameter int NUM_CORES = 4
);
    localparam int IDW = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0] Bus_RQ;
    logic                 Bus_Mem_Ready;
    logic [NUM_CORES-1:0] Bus_GRANT;
    logic [IDW-1:0]       Grant_Id;
    logic                 Bus_Busy;
    logic                 Timeout_Pulse;

    modport master (
        input  Bus_RQ, Bus_Mem_Ready,
        output Bus_GRANT, Grant_Id, Bus_Busy, Timeout_Pulse
    );

    modport slave (
        output Bus_RQ, Bus_Mem_Ready,
        input  Bus_GRANT, Grant_Id, Bus_Busy, Timeout_Pulse
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared memory bus; a new owner is only granted once memory Ready is low.
// Optional grant-tenure limit enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 64
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.master bus
);
    localparam int IDW = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE, WAIT_MEM_LOW} state_t;

    state_t               state_reg;
    logic [NUM_CORES-1:0] grant_reg;
    logic [IDW-1:0]       last_reg;
    logic                 busy_reg;

    logic [NUM_CORES-1:0] upper_mask;
    logic [NUM_CORES-1:0] upper_rq;
    logic [NUM_CORES-1:0] winner_onehot;
    logic [IDW-1:0]       winner;

    generate
        if (NUM_CORES < 2 || NUM_CORES > 16 || MAX_HOLD < 1) begin : g_bad_params
            $error("bus_arbiter_rr: parameter out of range");
        end
    endgenerate

    // Requests strictly above the last owner get first pick; otherwise wrap to core 0.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rr
            assign upper_mask[gi]    = (IDW'(gi) > last_reg);
            assign winner_onehot[gi] = (winner == IDW'(gi));
        end
    endgenerate

    assign upper_rq = bus.Bus_RQ & upper_mask;

    always_comb begin
        winner = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (upper_rq != '0) begin
                if (upper_rq[k]) winner = IDW'(k);
            end else if (bus.Bus_RQ[k]) begin
                winner = IDW'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_reg;
    logic          pulse_reg;
    assign bus.Timeout_Pulse = pulse_reg;
`else
    assign bus.Timeout_Pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= IDW'(NUM_CORES - 1);
            busy_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_reg  <= '0;
            pulse_reg <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            pulse_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if ((|bus.Bus_RQ) && !bus.Bus_Mem_Ready) begin
                        grant_reg <= winner_onehot;
                        last_reg  <= winner;
                        busy_reg  <= 1'b1;
                        state_reg <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_reg  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.Bus_RQ[last_reg]) begin
                        grant_reg <= '0;
                        state_reg <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Revoked owner stays as last, so every other requester is ahead of it.
                    else if (hold_reg == HW'(MAX_HOLD - 1)) begin
                        grant_reg <= '0;
                        state_reg <= RELEASE;
                        pulse_reg <= 1'b1;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    state_reg <= WAIT_MEM_LOW;
                end
                WAIT_MEM_LOW: begin
                    if (!bus.Bus_Mem_Ready) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.Bus_GRANT = grant_reg;
    assign bus.Grant_Id  = last_reg;
    assign bus.Bus_Busy  = busy_reg;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, checked every cycle against a tenure-level model.
module tb_bus_arbiter_rr;
    localparam int N  = 4;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.NUM_CORES(N)) bus ();

    bus_arbiter_rr #(.NUM_CORES(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: who owns the bus, how long they have held it, and where the turnaround stands.
    int m_owner  = -1;   // -1 when nobody holds the grant
    int m_gap    = 0;    // 0 free, 1 dead cycle pending, 2 waiting for Ready low
    int m_last   = N - 1;
    int m_tenure = 0;    // cycles the current owner has held the grant
    int m_pulse  = 0;
    bit m_valid  = 0;

    initial begin
        logic [N-1:0] s_rq;
        logic         s_rdy;
        logic         s_rst;
        int           c;
        forever begin
            @(posedge clk);
            s_rq  = bus.Bus_RQ;
            s_rdy = bus.Bus_Mem_Ready;
            s_rst = reset;
            if (s_rst) begin
                m_owner = -1; m_gap = 0; m_last = N - 1; m_tenure = 0; m_pulse = 0; m_valid = 1;
            end else begin
                m_pulse = 0;
                if (m_owner >= 0) begin
                    if (!s_rq[m_owner]) begin
                        m_owner = -1; m_gap = 1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (m_tenure >= MH) begin
                        m_owner = -1; m_gap = 1; m_pulse = 1;
                    end
`endif
                    else begin
                        m_tenure++;
                    end
                end else if (m_gap == 1) begin
                    m_gap = 2;
                end else if (m_gap == 2) begin
                    if (!s_rdy) m_gap = 0;
                end else if (s_rq != '0 && !s_rdy) begin
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (s_rq[c] && m_owner < 0) m_owner = c;
                    end
                    m_last   = m_owner;
                    m_tenure = 1;
                end
            end
            @(negedge clk);
            if (m_valid) begin
                chk("model_grant", int'(bus.Bus_GRANT), (m_owner >= 0) ? (1 << m_owner) : 0);
                chk("model_id", int'(bus.Grant_Id), m_last);
                chk("model_busy", int'(bus.Bus_Busy), (m_owner >= 0 || m_gap != 0) ? 1 : 0);
                chk("model_pulse", int'(bus.Timeout_Pulse), m_pulse);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        int low;
        int guard;
        int cnt;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        bus.Bus_RQ = '0;
        bus.Bus_Mem_Ready = 1'b0;

        // Reset then idle
        step(2);
        reset = 1'b0;
        chk("rst_grant", int'(bus.Bus_GRANT), 0);
        chk("rst_id", int'(bus.Grant_Id), 3);
        chk("rst_busy", int'(bus.Bus_Busy), 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_grant", int'(bus.Bus_GRANT), 0);
        end
        chk("idle_id", int'(bus.Grant_Id), 3);

        // Single request, release held up by Ready
        bus.Bus_RQ = 4'b0100;
        step(1);
        chk("single_grant", int'(bus.Bus_GRANT), 4);
        chk("single_busy", int'(bus.Bus_Busy), 1);
        chk("single_id", int'(bus.Grant_Id), 2);
        bus.Bus_RQ = '0;
        bus.Bus_Mem_Ready = 1'b1;
        step(1);
        chk("single_release", int'(bus.Bus_GRANT), 0);
        chk("single_busy_rel", int'(bus.Bus_Busy), 1);
        step(4);
        chk("single_busy_wait", int'(bus.Bus_Busy), 1);
        bus.Bus_Mem_Ready = 1'b0;
        step(1);
        chk("single_busy_fall", int'(bus.Bus_Busy), 0);
        chk("single_id_hold", int'(bus.Grant_Id), 2);

        // Round-robin fairness with all cores requesting
        pulse_reset();
        bus.Bus_RQ = 4'b1111;
        low = 0;
        for (int i = 0; i < 5; i++) begin
            guard = 0;
            while (bus.Bus_GRANT == '0 && guard < 20) begin
                low++;
                step(1);
                guard++;
            end
            chk("rr_owner", int'(bus.Bus_GRANT), 1 << exp_order[i]);
            if (i > 0) chk("rr_gap", low, 3);
            step(2);
            bus.Bus_RQ = 4'b1111 & ~bus.Bus_GRANT;
            step(1);
            bus.Bus_RQ = 4'b1111;
            low = 0;
        end
        bus.Bus_RQ = '0;
        step(6);

        // Ready high blocks any grant
        pulse_reset();
        bus.Bus_RQ = 4'b0001;
        bus.Bus_Mem_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("ready_block", int'(bus.Bus_GRANT), 0);
        end
        bus.Bus_Mem_Ready = 1'b0;
        step(1);
        chk("ready_unblock", int'(bus.Bus_GRANT), 1);
        bus.Bus_RQ = '0;
        step(4);

        // Reset in the middle of a tenure
        pulse_reset();
        bus.Bus_RQ = 4'b0100;
        step(1);
        chk("midrst_grant", int'(bus.Bus_GRANT), 4);
        step(2);
        reset = 1'b1;
        step(1);
        chk("midrst_drop", int'(bus.Bus_GRANT), 0);
        chk("midrst_id", int'(bus.Grant_Id), 3);
        chk("midrst_busy", int'(bus.Bus_Busy), 0);
        reset = 1'b0;
        step(1);
        chk("midrst_regrant", int'(bus.Bus_GRANT), 4);
        chk("midrst_reid", int'(bus.Grant_Id), 2);
        bus.Bus_RQ = '0;
        step(5);

        // Long tenure: revoked with the limit, unbounded without it
        pulse_reset();
        bus.Bus_RQ = 4'b0011;
        step(1);
        chk("hold_first", int'(bus.Bus_GRANT), 1);
        cnt = 0;
        while (bus.Bus_GRANT == 4'b0001 && cnt < 200) begin
            cnt++;
            step(1);
        end
`ifdef ARB_TIMEOUT_EN
        chk("timeout_tenure", cnt, 16);
        chk("timeout_pulse", int'(bus.Timeout_Pulse), 1);
        step(1);
        chk("timeout_pulse_end", int'(bus.Timeout_Pulse), 0);
        guard = 0;
        while (bus.Bus_GRANT == '0 && guard < 20) begin
            step(1);
            guard++;
        end
        chk("timeout_next", int'(bus.Bus_GRANT), 2);
`else
        chk("hold_tenure", cnt, 200);
        chk("hold_no_pulse", int'(bus.Timeout_Pulse), 0);
`endif
        bus.Bus_RQ = '0;
        step(6);

        // Random traffic against the model
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) bus.Bus_RQ = 4'($urandom_range(0, 15));
            bus.Bus_Mem_Ready = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step(1);
        end
        reset = 1'b0;
        bus.Bus_RQ = '0;
        bus.Bus_Mem_Ready = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
